// File: rtl/id_hazard_unit.sv
// Decode-stage hazard and bypass controller: a two-entry scoreboard of the IX/MEM
// destinations drives the load-use stall, the MX/WX/WM bypass selects and a stall counter.
module id_hazard_unit #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_is_store,
    input  logic [4:0]       id_dest_reg,
    input  logic             id_write_to_reg,
    input  logic             id_is_load,
    input  logic             flush,
    output logic             stall,
    output logic             mx_op1_bypass,
    output logic             mx_op2_bypass,
    output logic             wx_op1_bypass,
    output logic             wx_op2_bypass,
    output logic             wm_data_bypass,
    output logic [CNT_W-1:0] stall_count
);

    localparam int unsigned REG_W = 5;

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] dest;
        logic             ld;
    } sb_entry_t;

    sb_entry_t ix_q;
    sb_entry_t mem_q;
    sb_entry_t ix_d;

    logic ix_rs_hit;
    logic ix_rt_hit;
    logic mem_rs_hit;
    logic mem_rt_hit;
    logic fwd_ok;

    // Register 0 is hard-wired, so it never matches a producer.
    always_comb begin
        ix_rs_hit  = ix_q.v  && (ix_q.dest  == id_rs) && (id_rs != '0);
        ix_rt_hit  = ix_q.v  && (ix_q.dest  == id_rt) && (id_rt != '0);
        mem_rs_hit = mem_q.v && (mem_q.dest == id_rs) && (id_rs != '0);
        mem_rt_hit = mem_q.v && (mem_q.dest == id_rt) && (id_rt != '0);
    end

    // Store data from an IX load is bypassed later in MEM, so it does not stall.
    always_comb begin
        stall          = 1'b0;
        fwd_ok         = 1'b0;
        mx_op1_bypass  = 1'b0;
        mx_op2_bypass  = 1'b0;
        wx_op1_bypass  = 1'b0;
        wx_op2_bypass  = 1'b0;
        wm_data_bypass = 1'b0;

        stall = id_valid && ix_q.ld &&
                ((id_uses_rs && ix_rs_hit) ||
                 (id_uses_rt && ix_rt_hit && !id_is_store));
        fwd_ok = id_valid && !stall;

        mx_op1_bypass  = fwd_ok && id_uses_rs && ix_rs_hit && !ix_q.ld;
        mx_op2_bypass  = fwd_ok && id_uses_rt && ix_rt_hit && !ix_q.ld;
        wx_op1_bypass  = fwd_ok && id_uses_rs && mem_rs_hit && !ix_rs_hit;
        wx_op2_bypass  = fwd_ok && id_uses_rt && mem_rt_hit && !ix_rt_hit;
        wm_data_bypass = fwd_ok && id_is_store && ix_rt_hit && ix_q.ld;
    end

    // A stalled or flushed ID instruction enters IX as a bubble.
    always_comb begin
        ix_d = '0;
        if (!stall && !flush) begin
            ix_d.v    = id_valid && id_write_to_reg;
            ix_d.dest = id_dest_reg;
            ix_d.ld   = id_is_load;
        end
    end

    // Scoreboard advances with the pipeline registers on the falling edge.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ix_q  <= '0;
            mem_q <= '0;
        end else begin
            mem_q <= ix_q;
            ix_q  <= ix_d;
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule
